// File: rtl/i2s_pkg.sv
// Shared I2S definitions: serializer FSM states and frame-size helper, reused by the tx and rx paths.
package i2s_pkg;

  typedef enum logic {I2S_IDLE = 1'b0, I2S_RUN = 1'b1} i2s_state_t;

  function automatic int FRAME_BITS(input int s);
    return 2 * s;
  endfunction

endpackage

// File: rtl/i2s_frame_counter.sv
// I2S frame timing: IDLE/RUN state, bit counter, LRCLK decode, frameStart and load-cycle strobes.
module i2s_frame_counter
  import i2s_pkg::*;
#(
  parameter int SLOT_WIDTH = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic enable_i,
  output logic run_o,
  output logic lrclk_o,
  output logic frameStart_o,
  output logic isLoad_o,
  output logic load_o
);

  localparam int FB = FRAME_BITS(SLOT_WIDTH);
  localparam int CW = $clog2(FB);
  localparam logic [CW-1:0] LAST   = CW'(FB - 1);
  localparam logic [CW-1:0] RSTART = CW'(SLOT_WIDTH - 1);

  i2s_state_t    state_q, state_d;
  logic [CW-1:0] bitCnt_q, bitCnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= I2S_IDLE;
      bitCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
    end
  end

  // Entering RUN lands on the last bit so the first RUN cycle is a load cycle.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    case (state_q)
      I2S_IDLE: begin
        if (enable_i) begin
          state_d  = I2S_RUN;
          bitCnt_d = LAST;
        end
      end
      I2S_RUN: begin
        bitCnt_d = (bitCnt_q == LAST) ? '0 : bitCnt_q + 1'b1;
        if (bitCnt_q == LAST && !enable_i) state_d = I2S_IDLE;
      end
      default: state_d = I2S_IDLE;
    endcase
  end

  assign run_o        = (state_q == I2S_RUN);
  assign isLoad_o     = run_o && (bitCnt_q == LAST);
  assign load_o       = isLoad_o && enable_i;
  assign frameStart_o = run_o && (bitCnt_q == '0);
  // LRCLK switches one bit ahead of each slot's MSB.
  assign lrclk_o      = !run_o || ((bitCnt_q >= RSTART) && (bitCnt_q != LAST));

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: holds the latest mono sample, sends it on both slots, tracks underruns.
// Define TX_UNDERRUN_MUTE_EN to send silence on underrun frames instead of repeating the last sample.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int PKT_WIDTH     = 16,
  parameter int SLOT_WIDTH    = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [PKT_WIDTH-1:0]     pkt_i,
  input  logic                     pktChanged_i,
  input  logic                     enable_i,
  output logic                     lrclk_o,
  output logic                     sd_o,
  output logic                     frameStart_o,
  output logic                     underrun_o,
  output logic [ERR_CNT_WIDTH-1:0] underrunCnt_o
);

  localparam int FB = FRAME_BITS(SLOT_WIDTH);

  logic                     run, isLoad, load, starved;
  logic [PKT_WIDTH-1:0]     holdReg_q, holdReg_d, frameSample;
  logic                     fresh_q, fresh_d;
  logic                     underrun_q, underrun_d;
  logic [ERR_CNT_WIDTH-1:0] underrunCnt_q, underrunCnt_d;
  logic [FB-1:0]            shifter_q, shifter_d;

  i2s_frame_counter #(.SLOT_WIDTH(SLOT_WIDTH)) u_cnt (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .enable_i     (enable_i),
    .run_o        (run),
    .lrclk_o      (lrclk_o),
    .frameStart_o (frameStart_o),
    .isLoad_o     (isLoad),
    .load_o       (load)
  );

  function automatic logic [FB-1:0] build_frame(input logic [PKT_WIDTH-1:0] s);
    logic [SLOT_WIDTH-1:0] slot;
    slot = SLOT_WIDTH'(s) << (SLOT_WIDTH - PKT_WIDTH);
    return {slot, slot};
  endfunction

  assign starved = load && !pktChanged_i && !fresh_q;

  // A strobe on the load cycle bypasses the hold register.
  always_comb begin
    frameSample = pktChanged_i ? pkt_i : holdReg_q;
`ifdef TX_UNDERRUN_MUTE_EN
    if (starved) frameSample = '0;
`endif
  end

  always_comb begin
    holdReg_d     = holdReg_q;
    fresh_d       = fresh_q;
    underrun_d    = underrun_q;
    underrunCnt_d = underrunCnt_q;
    shifter_d     = '0;
    if (pktChanged_i) holdReg_d = pkt_i;
    if (load)              fresh_d = 1'b0;
    else if (pktChanged_i) fresh_d = 1'b1;
    if (starved) begin
      underrun_d = 1'b1;
      if (underrunCnt_q != '1) underrunCnt_d = underrunCnt_q + 1'b1;
    end
    // Shifter drains to zero so a fresh RUN entry starts with sd low.
    if (load)                shifter_d = build_frame(frameSample);
    else if (run && !isLoad) shifter_d = {shifter_q[FB-2:0], 1'b0};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      holdReg_q     <= '0;
      fresh_q       <= 1'b0;
      underrun_q    <= 1'b0;
      underrunCnt_q <= '0;
      shifter_q     <= '0;
    end else begin
      holdReg_q     <= holdReg_d;
      fresh_q       <= fresh_d;
      underrun_q    <= underrun_d;
      underrunCnt_q <= underrunCnt_d;
      shifter_q     <= shifter_d;
    end
  end

  assign sd_o          = run & shifter_q[FB-1];
  assign underrun_o    = underrun_q;
  assign underrunCnt_o = underrunCnt_q;

endmodule
